// File: rtl/gear_input_conditioner_if.sv
// Driver-input / shift-request bundle between the driver controls and the gearbox input stage.
interface gear_input_conditioner_if;
  logic ena;
  logic shift_up_raw;
  logic shift_down_raw;
  logic brake_raw;
  logic shift_up_pulse;
  logic shift_down_pulse;
  logic brake_level;
  logic lockout_active;

  modport master (
    output ena, shift_up_raw, shift_down_raw, brake_raw,
    input  shift_up_pulse, shift_down_pulse, brake_level, lockout_active
  );

  modport slave (
    input  ena, shift_up_raw, shift_down_raw, brake_raw,
    output shift_up_pulse, shift_down_pulse, brake_level, lockout_active
  );
endinterface

// File: rtl/gear_input_conditioner.sv
// Synchronise + debounce the up/down/brake driver inputs, then arbitrate into
// single-cycle shift requests with brake inhibit, conflict drop and rate limiting.
module gear_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250,
  parameter int LOCKOUT_CYCLES  = 2500
) (
  input logic                      clk,
  input logic                      rst_n,
  gear_input_conditioner_if.slave  bus
);
  localparam int NUM_LANES = 3;
  localparam int UP = 0, DN = 1, BRK = 2;
  localparam logic [11:0] LOCK_LOAD = 12'(LOCKOUT_CYCLES);

  logic [NUM_LANES-1:0] raw, lvl;
  logic [1:0]           lvl_q, rise;
  logic [11:0]          lock_cnt;
  logic                 up_pulse, dn_pulse;
  logic                 lock_on, up_ok, dn_ok;

  assign raw = {bus.brake_raw, bus.shift_down_raw, bus.shift_up_raw};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    gic_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw[i]),
      .level (lvl[i])
    );
  end

  assign rise    = lvl[DN:UP] & ~lvl_q;
  assign lock_on = (lock_cnt != 12'd0);

  // Brake is taken post-update, so a brake and up edge on the same clock blocks the up.
  assign up_ok = bus.ena & ~lock_on & rise[UP] & ~rise[DN] & ~lvl[BRK];
  assign dn_ok = bus.ena & ~lock_on & rise[DN] & ~rise[UP];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q    <= '0;
      up_pulse <= 1'b0;
      dn_pulse <= 1'b0;
      lock_cnt <= '0;
    end else begin
      lvl_q    <= lvl[DN:UP];
      up_pulse <= up_ok;
      dn_pulse <= dn_ok;
      if (up_ok || dn_ok)  lock_cnt <= LOCK_LOAD;
      else if (lock_on)    lock_cnt <= lock_cnt - 12'd1;
    end
  end

  assign bus.shift_up_pulse   = up_pulse;
  assign bus.shift_down_pulse = dn_pulse;
  assign bus.brake_level      = lvl[BRK];
  assign bus.lockout_active   = lock_on;
endmodule

// Per-input 2-flop synchroniser followed by a stable-count debouncer.
module gic_debounce #(
  parameter int DEBOUNCE_CYCLES = 250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);
  localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

  logic [1:0] sync;
  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_gear_input_conditioner.sv
// Scoreboard bench: expected pulse cycles are queued when buttons are driven, popped as pulses appear.
module tb_gear_input_conditioner;
  localparam int DEB  = 4;
  localparam int LOCK = 8;
  localparam int LAT  = DEB + 3;   // drive cycle -> pulse cycle
  localparam logic [1:0] K_UP = 2'b10, K_DN = 2'b01;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0, n_chk = 0, n_err = 0;

  typedef struct { int cyc; logic [1:0] kind; } exp_t;
  exp_t sb[$];

  gear_input_conditioner_if bus();

  gear_input_conditioner #(.DEBOUNCE_CYCLES(DEB), .LOCKOUT_CYCLES(LOCK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic expect_pulse(input logic [1:0] kind);
    exp_t e;
    e.cyc  = cyc + LAT;
    e.kind = kind;
    sb.push_back(e);
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_up"},   int'(bus.shift_up_pulse),   0);
    chk({tag, "_dn"},   int'(bus.shift_down_pulse), 0);
    chk({tag, "_brk"},  int'(bus.brake_level),      0);
    chk({tag, "_lock"}, int'(bus.lockout_active),   0);
  endtask

  // Pulse monitor: every pulse must match the head of the queue; overdue entries are misses.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      chk("missed_pulse", cyc, e.cyc);
    end
    if (bus.shift_up_pulse || bus.shift_down_pulse) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", int'({bus.shift_up_pulse, bus.shift_down_pulse}), 0);
      end else begin
        e = sb.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_kind", int'({bus.shift_up_pulse, bus.shift_down_pulse}), int'(e.kind));
      end
    end
  end

  initial begin
    bus.ena = 1'b1;
    bus.shift_up_raw = 1'b0;
    bus.shift_down_raw = 1'b0;
    bus.brake_raw = 1'b1;           // active during reset, must not leak out
    step(4);
    chk_outs_zero("reset");
    bus.brake_raw = 1'b0;
    rst_n = 1'b1;
    step(10);

    // Clean press with lockout window
    bus.shift_up_raw = 1'b1; expect_pulse(K_UP);
    step(6);  chk("lock_pre",   int'(bus.lockout_active), 0);
    step(1);  chk("lock_first", int'(bus.lockout_active), 1);
    step(7);  chk("lock_last",  int'(bus.lockout_active), 1);
    step(1);  chk("lock_done",  int'(bus.lockout_active), 0);
    step(5);
    bus.shift_up_raw = 1'b0;
    step(20);

    // Bounce on down, then stable
    bus.shift_down_raw = 1'b1; step(1);
    bus.shift_down_raw = 1'b0; step(1);
    bus.shift_down_raw = 1'b1; step(1);
    bus.shift_down_raw = 1'b0; step(1);
    bus.shift_down_raw = 1'b1; expect_pulse(K_DN);
    step(20);
    bus.shift_down_raw = 1'b0;
    step(20);

    // Brake inhibit
    bus.brake_raw = 1'b1;
    step(5); chk("brake_early", int'(bus.brake_level), 0);
    step(1); chk("brake_rise",  int'(bus.brake_level), 1);
    step(4);
    bus.shift_up_raw = 1'b1;   step(10);
    bus.shift_up_raw = 1'b0;   step(10);
    bus.shift_down_raw = 1'b1; expect_pulse(K_DN); step(10);
    bus.shift_down_raw = 1'b0; step(20);
    bus.brake_raw = 1'b0;
    step(10); chk("brake_fall", int'(bus.brake_level), 0);
    bus.shift_up_raw = 1'b1;   expect_pulse(K_UP); step(10);
    bus.shift_up_raw = 1'b0;   step(20);

    // Same-edge conflict
    bus.shift_up_raw = 1'b1; bus.shift_down_raw = 1'b1; step(10);
    bus.shift_up_raw = 1'b0; bus.shift_down_raw = 1'b0; step(20);

    // Down lands 3 cycles after up pulse -> dropped; retried after lockout -> accepted
    bus.shift_up_raw = 1'b1; expect_pulse(K_UP); step(3);
    bus.shift_down_raw = 1'b1; step(20);
    bus.shift_up_raw = 1'b0; bus.shift_down_raw = 1'b0; step(20);
    bus.shift_down_raw = 1'b1; expect_pulse(K_DN); step(10);
    bus.shift_down_raw = 1'b0; step(20);

    // Down edge on last lockout cycle -> dropped
    bus.shift_up_raw = 1'b1; expect_pulse(K_UP); step(8);
    bus.shift_down_raw = 1'b1; step(12);
    bus.shift_up_raw = 1'b0; bus.shift_down_raw = 1'b0; step(20);

    // Down edge on the cycle the counter reaches 0 -> accepted
    bus.shift_up_raw = 1'b1; expect_pulse(K_UP); step(9);
    bus.shift_down_raw = 1'b1; expect_pulse(K_DN); step(12);
    bus.shift_up_raw = 1'b0; bus.shift_down_raw = 1'b0; step(20);

    // Enable low during press, then high while still held
    bus.ena = 1'b0; bus.shift_up_raw = 1'b1; step(15);
    bus.ena = 1'b1; step(15);
    bus.shift_up_raw = 1'b0; step(20);

    // Reset mid-lockout with up held through release
    bus.shift_up_raw = 1'b1; expect_pulse(K_UP); step(8);
    chk("lock_before_rst", int'(bus.lockout_active), 1);
    rst_n = 1'b0; #1;
    chk_outs_zero("mid_rst");
    step(3);
    rst_n = 1'b1; expect_pulse(K_UP);
    step(15);
    bus.shift_up_raw = 1'b0;
    step(30);

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/gear_input_conditioner.md
# gear_input_conditioner

Input conditioning stage in front of the gearbox FSM. Synchronises the three raw driver inputs (shift-up, shift-down, brake), debounces each, and emits single-cycle shift request pulses plus a clean brake level. It enforces the input-side policy: brake blocks upshifts, conflicting requests are dropped, and shift requests are rate-limited.

## Interface
- DEBOUNCE_CYCLES, 250: consecutive stable cycles before a debounced level changes (10 ms at 25 kHz); legal range 2..255.
- LOCKOUT_CYCLES, 2500: minimum spacing in cycles between emitted shift pulses (100 ms); legal range 1..4095.

- clk  in  1  system clock, 25 kHz nominal
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  block enable; low suppresses pulse generation
- shift_up_raw  in  1  raw up button, active high, asynchronous
- shift_down_raw  in  1  raw down button, active high, asynchronous
- brake_raw  in  1  raw brake switch, active high, asynchronous
- shift_up_pulse  out  1  one-cycle upshift request to gearbox FSM
- shift_down_pulse  out  1  one-cycle downshift request to gearbox FSM
- brake_level  out  1  debounced brake state
- lockout_active  out  1  high while the shift lockout counter is running

## Operation
- Per input: 2-flop synchroniser, then debouncer. Counter clears whenever the synchronised value equals the debounced level; otherwise it increments. When it holds DEBOUNCE_CYCLES-1 and the inputs still differ, the debounced level toggles and the counter clears. A single glitch cycle restarts the count.
- Rising-edge detect on the debounced up/down levels. Falling edges produce nothing.
- Pulse arbitration, evaluated in a cycle with at least one rising edge:
  - ena low: drop all edges.
  - lockout_active high: drop (no queueing).
  - up and down edges in the same cycle: drop both.
  - up edge while debounced brake high: drop. Down edges are unaffected by brake.
  - otherwise: register the corresponding pulse.
- Lockout: an emitted pulse loads a 12-bit counter with LOCKOUT_CYCLES. It decrements each cycle and lockout_active = (counter != 0). The counter keeps running while ena is low.
- brake_level is the debounced brake flop, driven directly with no extra stage.
- A held button produces exactly one pulse per press. No auto-repeat.

## Timing
- Reset (asynchronous assert, synchronous release by the clock): all synchroniser, debounce, counter and output flops clear to 0.
  - All outputs are 0 during reset.
  - A button held through reset is seen as a new press after release and yields a pulse after the normal latency, subject to arbitration.
- Latency, with raw first sampled high at edge N and held stable:
  - debounced level toggles at edge N+1+DEBOUNCE_CYCLES.
  - shift pulse is high for exactly one cycle after edge N+2+DEBOUNCE_CYCLES.
  - brake_level rises at edge N+1+DEBOUNCE_CYCLES.
- Lockout counter loads on the same edge the pulse is registered. lockout_active is high from that edge for LOCKOUT_CYCLES cycles.
- A rising edge that arrives on the cycle the counter reaches 0 is accepted.
- Brake blocking uses the brake debounced level as of the same edge as the up edge. If brake and up debounced levels both toggle on the same edge, the up edge is blocked.
- Reset mid-lockout or mid-debounce: everything clears immediately. No pulse is emitted by the reset itself.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8, ena=1 unless noted.
- Clean press: shift_up_raw high from edge 10 and held for 20 cycles -> shift_up_pulse high only in the cycle after edge 16. No further pulse while held or on release. lockout_active high for 8 cycles.
- Bounce: shift_down_raw toggles 1,0,1,0 on consecutive cycles, then stays high -> exactly one shift_down_pulse, DEBOUNCE_CYCLES+2 cycles after the final stable rise is sampled.
- Brake inhibit: brake_raw held high (brake_level=1), then press up and separately press down -> no shift_up_pulse, one shift_down_pulse. Release brake, press up -> one shift_up_pulse.
- Conflict and lockout: up and down pressed on the same edge -> no pulses. Later, press up; then press down so its debounced edge lands 3 cycles after the up pulse -> down dropped. Repeat the down press after lockout expires -> accepted.
- Enable and reset: ena=0 during a press -> no pulse; ena=1 with the button still held -> no pulse. Assert rst_n low while lockout_active=1 -> all outputs 0 immediately. Up held through reset release -> one pulse 6 cycles after release.
